// File: rtl/median_filter_3x3_pkg.sv
// Shared constants and pixel type for the 3x3 median filter.
package median_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int IMG_W_DEFAULT = 1920;
  localparam int MF_LAT        = 4;

  typedef logic [DW_DEFAULT-1:0] pixel_t;

endpackage

// File: rtl/median_filter_3x3_if.sv
// Raster video port: input frame/line qualifiers and pixel, output qualifiers and median pixel.
interface median_filter_3x3_if
  import median_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic          vvalid;
  logic          hvalid;
  logic [DW-1:0] din;
  logic          fsync;
  logic          hsync;
  logic [DW-1:0] dout;

  modport master (output vvalid, hvalid, din, input fsync, hsync, dout);
  modport slave  (input vvalid, hvalid, din, output fsync, hsync, dout);

endinterface

// File: rtl/median_filter_3x3_median3_sort.sv
// Combinational unsigned sort of three values into min/mid/max.
module median3_sort
  import median_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] mid,
  output logic [DW-1:0] hi
);

  logic [DW-1:0] ab_lo;
  logic [DW-1:0] ab_hi;

  always_comb begin
    if (a < b) begin
      ab_lo = a;
      ab_hi = b;
    end else begin
      ab_lo = b;
      ab_hi = a;
    end
    lo  = (c < ab_lo) ? c : ab_lo;
    hi  = (c > ab_hi) ? c : ab_hi;
    if (c < ab_lo)
      mid = ab_lo;
    else if (c > ab_hi)
      mid = ab_hi;
    else
      mid = c;
  end

endmodule

// File: rtl/median_filter_3x3.sv
// Streaming 3x3 median filter: two line buffers, 3x3 window, three-stage sorting network.
module median_filter_3x3
  import median_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = DW_DEFAULT,
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = 1080
) (
  input logic                clk,
  input logic                rst_b,
  median_filter_3x3_if.slave vid
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 3) ? $clog2(IMG_H + 1) : 2;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX = '1;

  logic          armed;
  logic          hvalid_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_en;
  logic          accept;
  logic          in_range;
  logic          line_end;
  logic          win_vld;
  logic          acc_q;
  logic [AW-1:0] wr_addr_q;

  // armed stays low after reset until vvalid is seen low, so a frame in progress is skipped
  assign frame_en = vid.vvalid && armed;
  assign accept   = vid.hvalid && frame_en;
  assign in_range = accept && (x != X_MAX);
  assign line_end = hvalid_q && !vid.hvalid;
  assign win_vld  = in_range && (x >= XW'(2)) && (y >= YW'(2));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      armed     <= 1'b0;
      hvalid_q  <= 1'b0;
      x         <= '0;
      y         <= '0;
      acc_q     <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      armed    <= armed | !vid.vvalid;
      hvalid_q <= vid.hvalid;
      if (!frame_en || line_end)
        x <= '0;
      else if (in_range)
        x <= x + XW'(1);
      if (!frame_en)
        y <= '0;
      else if (line_end && (y != Y_MAX))
        y <= y + YW'(1);
      acc_q     <= in_range;
      wr_addr_q <= x[AW-1:0];
    end
  end

  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] din_q;

  // The row y-2 buffer is refilled one clock later from the registered row y-1 read,
  // keeping each memory at one read and one write port.
  always_ff @(posedge clk) begin
    if (in_range) begin
      rd1             <= lb1[x[AW-1:0]];
      rd2             <= lb2[x[AW-1:0]];
      lb1[x[AW-1:0]]  <= vid.din;
      din_q           <= vid.din;
    end
    if (acc_q)
      lb2[wr_addr_q] <= rd1;
  end

  // win[col][row]: col 0 is the oldest column, row 0 the oldest line
  logic [DW-1:0] win [N][N];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++)
          win[c][r] <= '0;
    end else if (acc_q) begin
      for (int c = 0; c < N-1; c++)
        win[c] <= win[c+1];
      win[N-1][0] <= rd2;
      win[N-1][1] <= rd1;
      win[N-1][2] <= din_q;
    end
  end

  logic [DW-1:0] col_lo  [N];
  logic [DW-1:0] col_mid [N];
  logic [DW-1:0] col_hi  [N];
  logic [DW-1:0] s1_lo   [N];
  logic [DW-1:0] s1_mid  [N];
  logic [DW-1:0] s1_hi   [N];

  for (genvar g = 0; g < N; g++) begin : g_col
    median3_sort #(.DW(DW)) u_col (
      .a   (win[g][0]),
      .b   (win[g][1]),
      .c   (win[g][2]),
      .lo  (col_lo[g]),
      .mid (col_mid[g]),
      .hi  (col_hi[g])
    );
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int c = 0; c < N; c++) begin
        s1_lo[c]  <= '0;
        s1_mid[c] <= '0;
        s1_hi[c]  <= '0;
      end
    end else begin
      s1_lo  <= col_lo;
      s1_mid <= col_mid;
      s1_hi  <= col_hi;
    end
  end

  logic [DW-1:0] max_of_lo;
  logic [DW-1:0] med_of_mid;
  logic [DW-1:0] min_of_hi;
  logic [DW-1:0] unused_s2 [6];

  median3_sort #(.DW(DW)) u_s2_lo (
    .a(s1_lo[0]), .b(s1_lo[1]), .c(s1_lo[2]),
    .lo(unused_s2[0]), .mid(unused_s2[1]), .hi(max_of_lo)
  );

  median3_sort #(.DW(DW)) u_s2_mid (
    .a(s1_mid[0]), .b(s1_mid[1]), .c(s1_mid[2]),
    .lo(unused_s2[2]), .mid(med_of_mid), .hi(unused_s2[3])
  );

  median3_sort #(.DW(DW)) u_s2_hi (
    .a(s1_hi[0]), .b(s1_hi[1]), .c(s1_hi[2]),
    .lo(min_of_hi), .mid(unused_s2[4]), .hi(unused_s2[5])
  );

  logic [DW-1:0] s2_a;
  logic [DW-1:0] s2_b;
  logic [DW-1:0] s2_c;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s2_a <= '0;
      s2_b <= '0;
      s2_c <= '0;
    end else begin
      s2_a <= max_of_lo;
      s2_b <= med_of_mid;
      s2_c <= min_of_hi;
    end
  end

  logic [DW-1:0] med;
  logic [DW-1:0] unused_s3_lo;
  logic [DW-1:0] unused_s3_hi;

  median3_sort #(.DW(DW)) u_s3 (
    .a(s2_a), .b(s2_b), .c(s2_c),
    .lo(unused_s3_lo), .mid(med), .hi(unused_s3_hi)
  );

  logic [MF_LAT:0] vpipe;
  logic [MF_LAT:0] fpipe;
  logic [DW-1:0]   dout_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vpipe  <= '0;
      fpipe  <= '0;
      dout_q <= '0;
    end else begin
      vpipe <= {vpipe[MF_LAT-1:0], win_vld};
      fpipe <= {fpipe[MF_LAT-1:0], frame_en};
      if (vpipe[MF_LAT-1])
        dout_q <= med;
    end
  end

  assign vid.fsync = fpipe[MF_LAT];
  assign vid.hsync = vpipe[MF_LAT];
  assign vid.dout  = dout_q;

endmodule

// File: tb/tb_median_filter_3x3.sv
// Directed bench for median_filter_3x3 with an 8-pixel line buffer.
module tb_median_filter_3x3;
  import median_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  median_filter_3x3_if #(.DW(8)) vid ();

  median_filter_3x3 #(.N(3), .DW(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .vid   (vid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_t img [H][W+3];
  pixel_t out_q [$];
  int     out_cyc [$];
  int     fs_cnt = 0;
  pixel_t exp_q [$];
  int     vectors = 0;
  int     miscompares = 0;
  int     acc22 = 0;

  always @(negedge clk) begin
    if (vid.hsync === 1'b1) begin
      out_q.push_back(vid.dout);
      out_cyc.push_back(cyc);
    end
    if (vid.fsync === 1'b1) fs_cnt = fs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic pixel_t med9(input int r, input int c);
    pixel_t v [9];
    pixel_t t;
    int k = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        v[k] = img[r+dr][c+dc];
        k++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  task automatic build_expected(input int w, input int h);
    exp_q.delete();
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++)
        exp_q.push_back(med9(r, c));
  endtask

  task automatic fill_const(input pixel_t v);
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W + 3; c++)
        img[r][c] = v;
  endtask

  task automatic fill_pattern(input int seed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W + 3; c++)
        img[r][c] = pixel_t'(((r * 53 + c * 29 + r * c * 7 + seed) ^ (c << 4)) & 8'hFF);
  endtask

  task automatic check_frame(input string tag, input int base);
    chk($sformatf("%s count", tag), out_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < out_q.size())
        chk($sformatf("%s px%0d", tag, i), out_q[base+i], exp_q[i]);
  endtask

  task automatic send_rows(input int r0, input int r1, input int w, input int hblank, input int long_row);
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < ((r == long_row) ? w + 3 : w); c++) begin
        @(negedge clk);
        vid.hvalid = 1'b1;
        vid.din    = img[r][c];
        if (r == 2 && c == 2) acc22 = cyc + 1;
      end
      @(negedge clk);
      vid.hvalid = 1'b0;
      vid.din    = '0;
      repeat (hblank - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int w, input int h, input int hblank, input int long_row);
    @(negedge clk);
    vid.vvalid = 1'b1;
    repeat (2) @(negedge clk);
    send_rows(0, h - 1, w, hblank, long_row);
    repeat (8) @(negedge clk);
    vid.vvalid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int base;
  int fs0;

  initial begin
    vid.vvalid = 1'b0;
    vid.hvalid = 1'b0;
    vid.din    = '0;
    repeat (3) @(negedge clk);
    chk("reset fsync", vid.fsync, 1'b0);
    chk("reset hsync", vid.hsync, 1'b0);
    chk("reset dout", vid.dout, 8'h00);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    // constant frame: every median equals the constant
    fill_const(8'h80);
    for (int i = 0; i < 24; i++) exp_q.push_back(8'h80);
    base = out_q.size();
    @(negedge clk);
    vid.vvalid = 1'b1;
    repeat (2) @(negedge clk);
    send_rows(0, 2, W, 2, -1);
    chk("fsync in frame", vid.fsync, 1'b1);
    send_rows(3, H - 1, W, 2, -1);
    repeat (8) @(negedge clk);
    vid.vvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("fsync after frame", vid.fsync, 1'b0);
    check_frame("const", base);

    // single impulse is removed completely
    fill_const(8'h00);
    img[3][4] = 8'hFF;
    for (int i = 0; i < 24; i++) exp_q.push_back(8'h00);
    base = out_q.size();
    send_frame(W, H, 3, -1);
    check_frame("impulse", base);

    // shuffled 1..9: column sorts {4,7,8},{2,3,5},{1,6,9} -> 4,6,5 -> 5
    fill_const(8'h00);
    img[0][0] = 8'd7; img[0][1] = 8'd2; img[0][2] = 8'd9;
    img[1][0] = 8'd4; img[1][1] = 8'd5; img[1][2] = 8'd1;
    img[2][0] = 8'd8; img[2][1] = 8'd3; img[2][2] = 8'd6;
    exp_q.push_back(8'd5);
    base = out_q.size();
    send_frame(3, 3, 4, -1);
    check_frame("nine", base);
    if (out_q.size() > base)
      chk("nine latency", out_cyc[base] - acc22, 4);
    else
      chk("nine latency present", out_q.size() - base, 1);

    // same image back-to-back and with long blanking
    fill_pattern(11);
    build_expected(W, H);
    base = out_q.size();
    send_frame(W, H, 1, -1);
    check_frame("pattern b2b", base);
    base = out_q.size();
    send_frame(W, H, 20, -1);
    check_frame("pattern gapped", base);

    // reset mid-frame: outputs clear at once and the rest of the frame is ignored
    fill_pattern(97);
    @(negedge clk);
    vid.vvalid = 1'b1;
    repeat (2) @(negedge clk);
    send_rows(0, 3, W, 2, -1);
    rst_b = 1'b0;
    #1;
    chk("midreset fsync", vid.fsync, 1'b0);
    chk("midreset hsync", vid.hsync, 1'b0);
    chk("midreset dout", vid.dout, 8'h00);
    @(negedge clk);
    rst_b = 1'b1;
    base = out_q.size();
    fs0  = fs_cnt;
    send_rows(4, H - 1, W, 2, -1);
    send_rows(0, H - 1, W, 2, -1);
    repeat (8) @(negedge clk);
    chk("midreset no hsync", out_q.size() - base, 0);
    chk("midreset no fsync", fs_cnt - fs0, 0);
    vid.vvalid = 1'b0;
    repeat (4) @(negedge clk);
    build_expected(W, H);
    base = out_q.size();
    send_frame(W, H, 2, -1);
    check_frame("after reset", base);

    // over-long line: extra pixels are dropped and must not corrupt the buffers
    fill_pattern(201);
    img[1][W]   = 8'hEE;
    img[1][W+1] = 8'hEE;
    img[1][W+2] = 8'hEE;
    build_expected(W, H);
    base = out_q.size();
    send_frame(W, H, 3, 1);
    check_frame("long line", base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
